calc_cmd_driver: RTL
====================

Name: calc_cmd_driver

Overview:
- Sequential front end for the team's 4-bit combinational calculator.
- Accepts operation commands over a valid/ready handshake and drives the calculator's OP/A/B inputs from registers.
- After one settle cycle, captures the calculator's R/ovf and presents the result over a second valid/ready handshake.
- Keeps an accumulator for operand chaining, a sticky overflow flag and a saturating operation counter.

Parameters:
COUNT_W, 8, width of the op_count counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  3  opcode: 000 A+B, 001 A-B, 01x abs(B), 100 B+A, 101 B-A, 11x abs(A)
cmd_a  input  4  operand A, two's complement
cmd_b  input  4  operand B, two's complement
cmd_chain  input  1  replace cmd_a with the accumulator value
calc_op  output  3  registered opcode to calculator
calc_a  output  4  registered operand A to calculator
calc_b  output  4  registered operand B to calculator
calc_r  input  4  calculator result
calc_ovf  input  1  calculator overflow
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_r  output  4  captured result
res_ovf  output  1  captured overflow
sticky_ovf  output  1  set by any captured overflow
ovf_clr  input  1  clears sticky_ovf
op_count  output  COUNT_W  number of captured results, saturating

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values (on a clk edge with reset=1):
  - state=IDLE, cmd_ready=1.
  - calc_op/calc_a/calc_b=0.
  - res_valid=0, res_r=0, res_ovf=0.
  - acc=0, sticky_ovf=0, op_count=0.
- Reset overrides every other input in the same cycle.
- FSM state IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid=1, load calc_op=cmd_op, calc_b=cmd_b, calc_a=(cmd_chain ? acc : cmd_a); go to DRIVE.
- FSM state DRIVE:
  - cmd_ready=0.
  - calc_* are held for the whole cycle so the combinational path settles.
  - At the edge ending DRIVE: res_r<=calc_r, res_ovf<=calc_ovf, acc<=calc_r, op_count increments (holds at all-ones); go to HOLD.
- FSM state HOLD:
  - res_valid=1, cmd_ready=0.
  - res_r/res_ovf are stable until handshake.
  - On an edge with res_ready=1, go to IDLE with res_valid=0.
  - Commands are not accepted in HOLD; cmd_valid is ignored.
- Latency:
  - Command accepted at edge k; calc_* valid after edge k.
  - res_valid high after edge k+1.
  - Minimum 3 cycles per command.
- calc_* outputs keep their last value outside DRIVE. No combinational path from calc_r to any output.
- sticky_ovf:
  - Set at the DRIVE capture edge when calc_ovf=1.
  - Cleared by ovf_clr in any state.
  - If set and clear occur on the same edge, set wins.
- Arithmetic is entirely in the calculator. This block does not alter operand values except the chain substitution.
- The accumulator captures every result, including abs results and overflowed results (overflowed results are subject to the optional feature below).
- Reset in DRIVE or HOLD discards the in-flight result; no res_valid pulse follows.

Optional Feature:
- Macro: CALC_OVF_HOLD_ACC_EN.
- Defined: on a capture with calc_ovf=1, acc keeps its previous value. res_r still shows the calculator result, and sticky_ovf and op_count update normally.
- Undefined: acc always loads calc_r.

Test Plan:
1. Reset held 2 cycles, then released -> cmd_ready=1, res_valid=0, calc_op/a/b=0, op_count=0, sticky_ovf=0.
2. cmd op=000 A=3 B=2, res_ready=1 -> calc_a=3 calc_b=2 one cycle after acceptance; res_valid high one cycle later with res_r=0101, res_ovf=0; op_count=1; back in IDLE next cycle.
3. Chained cmd op=001 chain=1 A=9(ignored) B=7 after test 2 -> calc_a=0101, res_r=1110 (-2), acc=1110.
4. cmd op=000 A=0111 B=0001 -> res_r=1000, res_ovf=1, sticky_ovf=1.
   - ovf_clr pulse -> sticky_ovf=0.
   - Repeat with ovf_clr asserted on the capture edge -> sticky_ovf=1.
   - With CALC_OVF_HOLD_ACC_EN defined, acc keeps its prior value.
5. res_ready held low 5 cycles in HOLD while cmd_valid=1 with new data -> res_r/res_ovf stable, cmd_ready=0, calc_* unchanged. The new command is accepted only after the res_ready handshake.
6. reset asserted in DRIVE of cmd op=110 A=1100 -> next cycle IDLE, res_valid never asserts, acc=0, op_count=0.

Source files
------------

// File: rtl/calc_cmd_driver.sv
// calc_cmd_driver: sequential front end for the 4-bit combinational calculator.
// It takes one command over a valid/ready handshake and drives calc_op/calc_a/calc_b
// from registers. After one settle cycle it captures calc_r/calc_ovf. It then holds
// the result on a second valid/ready handshake until the consumer takes it.
// It also keeps an accumulator for operand chaining, a sticky overflow flag and a
// saturating count of captured results.
//
// Optional feature: define CALC_OVF_HOLD_ACC_EN so that an overflowed result leaves
// the accumulator unchanged. res_r, sticky_ovf and op_count still update normally.
module calc_cmd_driver #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [3:0]         cmd_a,
  input  logic [3:0]         cmd_b,
  input  logic               cmd_chain,
  output logic [2:0]         calc_op,
  output logic [3:0]         calc_a,
  output logic [3:0]         calc_b,
  input  logic [3:0]         calc_r,
  input  logic               calc_ovf,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [3:0]         res_r,
  output logic               res_ovf,
  output logic               sticky_ovf,
  input  logic               ovf_clr,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [3:0] acc;
  logic       acc_load;

  // An overflowed result may be kept out of the accumulator when the option is built in.
`ifdef CALC_OVF_HOLD_ACC_EN
  assign acc_load = ~calc_ovf;
`else
  assign acc_load = 1'b1;
`endif

  // Command/result sequencer. All outputs are registered, so calc_r never reaches an
  // output combinationally. calc_* hold their value outside the accept edge.
  // NOTE: every register here uses non-blocking assignment, so each branch reads the
  // values from before the edge, whatever order the statements are written in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      calc_op   <= '0;
      calc_a    <= '0;
      calc_b    <= '0;
      res_valid <= 1'b0;
      res_r     <= '0;
      res_ovf   <= 1'b0;
      acc       <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            calc_op   <= cmd_op;
            calc_a    <= cmd_chain ? acc : cmd_a;
            calc_b    <= cmd_b;
            cmd_ready <= 1'b0;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          // The calculator has had a full cycle to settle on the held operands.
          res_r     <= calc_r;
          res_ovf   <= calc_ovf;
          if (acc_load) acc <= calc_r;
          if (op_count != COUNT_MAX) op_count <= op_count + COUNT_ONE;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          // New commands wait until the consumer has taken the result.
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Sticky overflow: an overflow seen at the capture edge wins over a clear on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_ovf <= 1'b0;
    end else if (state == DRIVE && calc_ovf) begin
      sticky_ovf <= 1'b1;
    end else if (ovf_clr) begin
      sticky_ovf <= 1'b0;
    end
  end

endmodule
